// File: rtl/bus_pkg.sv
// Shared constants for the 65816 bus wait sequencer: device indices, FSM states
// and the helper that tells whether a given device's select is still asserted.
package bus_pkg;

  localparam int WAIT_W_DEF = 4;

  localparam logic [2:0] DEV_EXP  = 3'd0;
  localparam logic [2:0] DEV_AIA  = 3'd1;
  localparam logic [2:0] DEV_VIA1 = 3'd2;
  localparam logic [2:0] DEV_VIA2 = 3'd3;
  localparam logic [2:0] DEV_XIA  = 3'd4;
  localparam logic [2:0] DEV_SIA  = 3'd5;
  localparam logic [2:0] DEV_RAM  = 3'd6;
  localparam logic [2:0] DEV_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXT  = 2'd2
  } state_t;

  // io_sel_n is ordered {exp,aia,via1,via2,xia,sia}, so device d sits at bit 5-d.
  function automatic logic dev_selected(input logic [2:0] dev,
                                        input logic [3:0] ram_n,
                                        input logic [5:0] io_sel_n);
    logic sel;
    sel = 1'b0;
    case (dev)
      DEV_EXP:  sel = ~io_sel_n[5];
      DEV_AIA:  sel = ~io_sel_n[4];
      DEV_VIA1: sel = ~io_sel_n[3];
      DEV_VIA2: sel = ~io_sel_n[2];
      DEV_XIA:  sel = ~io_sel_n[1];
      DEV_SIA:  sel = ~io_sel_n[0];
      DEV_RAM:  sel = ~&ram_n;
      default:  sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bus_wait_select.sv
// Combinational priority select of the active-low chip selects into the
// winning device, its stretch count and whether it is the expansion slot.
module bus_wait_select
  import bus_pkg::*;
#(
  parameter int WAIT_W   = WAIT_W_DEF,
  parameter int WAIT_RAM = 0,
  parameter int WAIT_EXP = 2,
  parameter int WAIT_AIA = 3,
  parameter int WAIT_VIA = 1,
  parameter int WAIT_XIA = 1,
  parameter int WAIT_SIA = 2
) (
  input  logic [3:0]        i_ram_n,
  input  logic [5:0]        i_io_sel_n,
  output logic              o_hit,
  output logic              o_is_exp,
  output logic [2:0]        o_dev,
  output logic [WAIT_W-1:0] o_wait_count
);

  // Priority: exp > aia > via1 > via2 > xia > sia > ram.
  always_comb begin
    o_dev        = DEV_NONE;
    o_wait_count = '0;
    if (!i_io_sel_n[5]) begin
      o_dev        = DEV_EXP;
      o_wait_count = WAIT_W'(WAIT_EXP);
    end else if (!i_io_sel_n[4]) begin
      o_dev        = DEV_AIA;
      o_wait_count = WAIT_W'(WAIT_AIA);
    end else if (!i_io_sel_n[3]) begin
      o_dev        = DEV_VIA1;
      o_wait_count = WAIT_W'(WAIT_VIA);
    end else if (!i_io_sel_n[2]) begin
      o_dev        = DEV_VIA2;
      o_wait_count = WAIT_W'(WAIT_VIA);
    end else if (!i_io_sel_n[1]) begin
      o_dev        = DEV_XIA;
      o_wait_count = WAIT_W'(WAIT_XIA);
    end else if (!i_io_sel_n[0]) begin
      o_dev        = DEV_SIA;
      o_wait_count = WAIT_W'(WAIT_SIA);
    end else if (!(&i_ram_n)) begin
      o_dev        = DEV_RAM;
      o_wait_count = WAIT_W'(WAIT_RAM);
    end
  end

  assign o_hit    = (o_dev != DEV_NONE);
  assign o_is_exp = (o_dev == DEV_EXP);

endmodule

// File: rtl/bus_wait_sequencer.sv
// Drives 65816 RDY low to stretch bus cycles to slow peripherals and the expansion slot.
// Optional feature: define BUS_TIMEOUT_EN to bound the expansion-slot handshake.
module bus_wait_sequencer
  import bus_pkg::*;
#(
  parameter int         WAIT_W      = WAIT_W_DEF,
  parameter int         WAIT_RAM    = 0,
  parameter int         WAIT_EXP    = 2,
  parameter int         WAIT_AIA    = 3,
  parameter int         WAIT_VIA    = 1,
  parameter int         WAIT_XIA    = 1,
  parameter int         WAIT_SIA    = 2,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic       i_phi2,
  input  logic       i_reset_n,
  input  logic       i_valid_address,
  input  logic       i_read_write,
  input  logic [3:0] i_ram_n,
  input  logic [5:0] i_io_sel_n,
  input  logic       i_exp_rdy_n,
  output logic       o_rdy,
  output logic       o_wait_active,
  output logic       o_last_rw,
  output logic       o_timeout_irq_n,
  input  logic       i_timeout_clr
);

  localparam int WAIT_MAX = (1 << WAIT_W) - 1;

  if (WAIT_RAM > WAIT_MAX || WAIT_EXP > WAIT_MAX || WAIT_AIA > WAIT_MAX ||
      WAIT_VIA > WAIT_MAX || WAIT_XIA > WAIT_MAX || WAIT_SIA > WAIT_MAX) begin : g_wait_range
    $error("bus_wait_sequencer: a wait parameter does not fit in WAIT_W bits");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_next;
  logic              r_rdy;
  logic              w_rdy_next;
  logic              r_last_rw;
  logic              w_last_rw_next;
  logic [2:0]        r_dev;
  logic [2:0]        w_dev_next;

  logic              w_hit;
  logic              w_is_exp;
  logic [2:0]        w_dev;
  logic [WAIT_W-1:0] w_wait_count;
  logic              w_hit_valid;
  logic              w_abort;

  bus_wait_select #(
    .WAIT_W  (WAIT_W),
    .WAIT_RAM(WAIT_RAM),
    .WAIT_EXP(WAIT_EXP),
    .WAIT_AIA(WAIT_AIA),
    .WAIT_VIA(WAIT_VIA),
    .WAIT_XIA(WAIT_XIA),
    .WAIT_SIA(WAIT_SIA)
  ) u_select (
    .i_ram_n     (i_ram_n),
    .i_io_sel_n  (i_io_sel_n),
    .o_hit       (w_hit),
    .o_is_exp    (w_is_exp),
    .o_dev       (w_dev),
    .o_wait_count(w_wait_count)
  );

  assign w_hit_valid = i_valid_address & w_hit;
  // A stretch is abandoned as soon as the CPU drops the access it was holding.
  assign w_abort     = ~i_valid_address | ~dev_selected(r_dev, i_ram_n, i_io_sel_n);

`ifdef BUS_TIMEOUT_EN
  logic [7:0] r_tcnt;
  logic       r_timeout_irq_n;
  logic       w_ext_entry;
  logic       w_timeout;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_rdy_next     = r_rdy;
    w_last_rw_next = r_last_rw;
    w_dev_next     = r_dev;
`ifdef BUS_TIMEOUT_EN
    w_ext_entry    = 1'b0;
    w_timeout      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_rdy_next = 1'b1;
        if (w_hit_valid && (w_wait_count != '0)) begin
          w_state_next   = ST_WAIT;
          w_cnt_next     = w_wait_count - WAIT_W'(1);
          w_rdy_next     = 1'b0;
          w_last_rw_next = i_read_write;
          w_dev_next     = w_dev;
        end else if (w_hit_valid && w_is_exp) begin
          w_state_next   = ST_EXT;
          w_rdy_next     = 1'b0;
          w_last_rw_next = i_read_write;
          w_dev_next     = w_dev;
`ifdef BUS_TIMEOUT_EN
          w_ext_entry    = 1'b1;
`endif
        end
      end
      ST_WAIT: begin
        if (w_abort) begin
          w_state_next = ST_IDLE;
          w_rdy_next   = 1'b1;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - WAIT_W'(1);
        end else if (r_dev == DEV_EXP) begin
          w_state_next = ST_EXT;
`ifdef BUS_TIMEOUT_EN
          w_ext_entry  = 1'b1;
`endif
        end else begin
          w_state_next = ST_IDLE;
          w_rdy_next   = 1'b1;
        end
      end
      ST_EXT: begin
        if (w_abort || i_exp_rdy_n) begin
          w_state_next = ST_IDLE;
          w_rdy_next   = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (r_tcnt == (TIMEOUT_CYC - 8'd1)) begin
          w_state_next = ST_IDLE;
          w_rdy_next   = 1'b1;
          w_timeout    = 1'b1;
        end
`endif
      end
      default: begin
        w_state_next = ST_IDLE;
        w_rdy_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_phi2 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rdy     <= 1'b1;
      r_last_rw <= 1'b1;
      r_dev     <= DEV_NONE;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rdy     <= w_rdy_next;
      r_last_rw <= w_last_rw_next;
      r_dev     <= w_dev_next;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // A timeout on the same edge as a clear keeps the flag asserted.
  always_ff @(posedge i_phi2 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tcnt          <= 8'd0;
      r_timeout_irq_n <= 1'b1;
    end else begin
      if (w_ext_entry) begin
        r_tcnt <= 8'd0;
      end else if (r_state == ST_EXT) begin
        r_tcnt <= r_tcnt + 8'd1;
      end
      if (w_timeout) begin
        r_timeout_irq_n <= 1'b0;
      end else if (i_timeout_clr) begin
        r_timeout_irq_n <= 1'b1;
      end
    end
  end

  assign o_timeout_irq_n = r_timeout_irq_n;
`else
  logic w_unused;
  assign w_unused        = ^{i_timeout_clr, TIMEOUT_CYC};
  assign o_timeout_irq_n = 1'b1;
`endif

  assign o_rdy         = r_rdy;
  assign o_wait_active = (r_state != ST_IDLE);
  assign o_last_rw     = r_last_rw;

endmodule

// File: tb/tb_bus_wait_sequencer.sv
// Scoreboard bench for bus_wait_sequencer: directed bus scenarios followed by a
// randomized CPU that holds its access while RDY is low, against a cycle-count model.
module tb_bus_wait_sequencer;

  localparam int WAIT_W   = 4;
  localparam int WAIT_RAM = 0;
  localparam int WAIT_EXP = 2;
  localparam int WAIT_AIA = 3;
  localparam int WAIT_VIA = 1;
  localparam int WAIT_XIA = 1;
  localparam int WAIT_SIA = 2;
`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CYC = 8'd16;
`else
  localparam logic [7:0] TIMEOUT_CYC = 8'd255;
`endif

  localparam logic [5:0] IO_NONE = 6'b111111;
  localparam logic [5:0] IO_EXP  = 6'b011111;
  localparam logic [5:0] IO_AIA  = 6'b101111;
  localparam logic [5:0] IO_VIA1 = 6'b110111;
  localparam logic [5:0] IO_VIA2 = 6'b111011;
  localparam logic [5:0] IO_XSIA = 6'b111100;

  logic       phi2 = 1'b0;
  logic       resetN = 1'b0;
  logic       valid = 1'b0;
  logic       rw = 1'b1;
  logic [3:0] ramN = 4'hF;
  logic [5:0] ioN = IO_NONE;
  logic       expRdyN = 1'b1;
  logic       tmoClr = 1'b0;
  logic       rdy;
  logic       waitActive;
  logic       lastRw;
  logic       tmoIrqN;

  bus_wait_sequencer #(
    .WAIT_W(WAIT_W), .WAIT_RAM(WAIT_RAM), .WAIT_EXP(WAIT_EXP), .WAIT_AIA(WAIT_AIA),
    .WAIT_VIA(WAIT_VIA), .WAIT_XIA(WAIT_XIA), .WAIT_SIA(WAIT_SIA), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_phi2(phi2), .i_reset_n(resetN), .i_valid_address(valid), .i_read_write(rw),
    .i_ram_n(ramN), .i_io_sel_n(ioN), .i_exp_rdy_n(expRdyN), .o_rdy(rdy),
    .o_wait_active(waitActive), .o_last_rw(lastRw), .o_timeout_irq_n(tmoIrqN),
    .i_timeout_clr(tmoClr)
  );

  always #5 phi2 = ~phi2;

  typedef struct packed {
    logic rdy;
    logic waitActive;
    logic lastRw;
    logic irqN;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: an access is "busy" for countLeft low-RDY cycles, then
  // (expansion slot only) until the slot reports ready.
  bit mBusy = 1'b0;
  int mDev = -1;
  int mCountLeft = 0;
  int mExtCycles = 0;
  bit mLastRw = 1'b1;
  bit mIrqN = 1'b1;

  function automatic int waitOf(input int d);
    case (d)
      0: return WAIT_EXP;
      1: return WAIT_AIA;
      2, 3: return WAIT_VIA;
      4: return WAIT_XIA;
      5: return WAIT_SIA;
      6: return WAIT_RAM;
      default: return 0;
    endcase
  endfunction

  function automatic int prioDev(input logic [3:0] rn, input logic [5:0] ion);
    for (int b = 5; b >= 0; b--) begin
      if (ion[b] == 1'b0) return 5 - b;
    end
    if (rn != 4'hF) return 6;
    return -1;
  endfunction

  function automatic bit devSel(input int d, input logic [3:0] rn, input logic [5:0] ion);
    if (d >= 0 && d <= 5) return ion[5-d] == 1'b0;
    if (d == 6) return rn != 4'hF;
    return 1'b0;
  endfunction

  task automatic modelStep(input logic v, input logic r, input logic [3:0] rn,
                           input logic [5:0] ion, input logic er, input logic clr);
    bit tmo;
    int d;
    tmo = 1'b0;
    if (!mBusy) begin
      d = v ? prioDev(rn, ion) : -1;
      if (d >= 0 && (waitOf(d) > 0 || d == 0)) begin
        mBusy      = 1'b1;
        mDev       = d;
        mCountLeft = waitOf(d);
        mExtCycles = 0;
        mLastRw    = r;
      end
    end else if (!v || !devSel(mDev, rn, ion)) begin
      mBusy = 1'b0;
    end else if (mCountLeft > 1) begin
      mCountLeft--;
    end else if (mCountLeft == 1) begin
      mCountLeft = 0;
      mExtCycles = 0;
      if (mDev != 0) mBusy = 1'b0;
    end else if (er) begin
      mBusy = 1'b0;
    end else begin
      mExtCycles++;
`ifdef BUS_TIMEOUT_EN
      if (mExtCycles == int'(TIMEOUT_CYC)) begin
        mBusy = 1'b0;
        tmo   = 1'b1;
      end
`endif
    end
`ifdef BUS_TIMEOUT_EN
    if (tmo) mIrqN = 1'b0;
    else if (clr) mIrqN = 1'b1;
`else
    if (tmo || clr) mIrqN = 1'b1;
`endif
  endtask

  task automatic checkOutput(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, got, want);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // One phi2 cycle: drive on the falling edge, model the rising edge, queue the expectation.
  task automatic applyStimulus(input logic v, input logic r, input logic [3:0] rn,
                               input logic [5:0] ion, input logic er, input logic clr);
    exp_t e;
    @(negedge phi2);
    valid = v; rw = r; ramN = rn; ioN = ion; expRdyN = er; tmoClr = clr;
    @(posedge phi2);
    #1;
    modelStep(v, r, rn, ion, er, clr);
    e.rdy = !mBusy; e.waitActive = mBusy; e.lastRw = mLastRw; e.irqN = mIrqN;
    sbQ.push_back(e);
  endtask

  task automatic midReset();
    @(negedge phi2);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("async_reset_rdy", rdy, 1'b1);
    checkOutput("async_reset_wait_active", waitActive, 1'b0);
    checkOutput("async_reset_last_rw", lastRw, 1'b1);
    mBusy = 1'b0; mLastRw = 1'b1; mIrqN = 1'b1; mDev = -1;
    @(posedge phi2);
    #2;
    resetN = 1'b1;
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge phi2);
      if (sbQ.size() > 0) begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("rdy", rdy, e.rdy);
        checkOutput("wait_active", waitActive, e.waitActive);
        checkOutput("last_rw", lastRw, e.lastRw);
        checkOutput("timeout_irq_n", tmoIrqN, e.irqN);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowCount;
    logic cv, cr, ce, cc;
    logic [3:0] crn;
    logic [5:0] cion;

    #12;
    checkOutput("reset_rdy", rdy, 1'b1);
    checkOutput("reset_wait_active", waitActive, 1'b0);
    checkOutput("reset_last_rw", lastRw, 1'b1);
    checkOutput("reset_timeout_irq_n", tmoIrqN, 1'b1);
    resetN = 1'b1;

    lowCount = 0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 4'hF, IO_VIA1, 1, 0);
      if (rdy == 1'b0) lowCount++;
    end
    checkCount("via1_stretch_cycles", lowCount, 1);

    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 4'hF, IO_AIA, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 4'hF, IO_VIA2, 1, 0);

    lowCount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 4'hF, IO_EXP, (i == 7), 0);
      if (rdy == 1'b0) lowCount++;
    end
    checkCount("exp_stretch_cycles", lowCount, 7);

    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 4'hF, IO_AIA, 1, 0);
    midReset();
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 4'hF, IO_VIA1, 1, 0);

    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 4'hF, IO_XSIA, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 4'hF, IO_XSIA, 1, 0);
    applyStimulus(1, 1, 4'h7, IO_NONE, 1, 0);

    for (int i = 0; i < 24; i++) applyStimulus(1, 1, 4'hF, IO_EXP, 0, 0);
    applyStimulus(1, 1, 4'hF, IO_EXP, 1, 0);
    applyStimulus(0, 1, 4'hF, IO_NONE, 1, 0);
    applyStimulus(0, 1, 4'hF, IO_NONE, 1, 1);
    applyStimulus(0, 1, 4'hF, IO_NONE, 1, 0);

    cv = 0; cr = 1; crn = 4'hF; cion = IO_NONE;
    for (int n = 0; n < 3000; n++) begin
      if (mBusy && $urandom_range(0, 19) != 0) begin
        ce = ($urandom_range(0, 3) == 0);
      end else if (mBusy) begin
        cv = 1'b0;
        ce = 1'b1;
      end else begin
        cv = ($urandom_range(0, 7) != 0);
        cr = 1'($urandom_range(0, 1));
        for (int b = 0; b < 6; b++) cion[b] = ($urandom_range(0, 4) != 0);
        for (int b = 0; b < 4; b++) crn[b] = ($urandom_range(0, 5) != 0);
        ce = ($urandom_range(0, 3) == 0);
      end
      cc = ($urandom_range(0, 15) == 0);
      applyStimulus(cv, cr, crn, cion, ce, cc);
    end

    repeat (3) @(negedge phi2);
    #1;
    checkCount("scoreboard_drained", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
